// File: rtl/ysyx_25020047_pkg.sv
// Shared constants for the NPC multi-cycle sequencer: decoded-type bit map,
// FSM state encoding, halt reasons and writeback/PC mux encodings.
package ysyx_25020047_pkg;

  localparam int IT_W      = 32;
  localparam int IT_ADDI   = 0;
  localparam int IT_JALR   = 1;
  localparam int IT_EBREAK = 2;
  localparam int IT_ADD    = 3;
  localparam int IT_LUI    = 4;
  localparam int IT_LW     = 5;
  localparam int IT_LBU    = 6;
  localparam int IT_SW     = 7;
  localparam int IT_SB     = 8;
  localparam int IT_AUIPC  = 9;
  localparam int IT_JAL    = 10;
  localparam int IT_SUB    = 11;
  localparam int IT_SLTI   = 12;
  localparam int IT_SLTIU  = 13;
  localparam int IT_BEQ    = 14;
  localparam int IT_BNE    = 15;
  localparam int IT_SLT    = 16;
  localparam int IT_SLTU   = 17;
  localparam int IT_XOR    = 18;
  localparam int IT_OR     = 19;
  localparam int IT_AND    = 20;
  localparam int IT_SH     = 21;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  localparam logic [1:0] HC_RUN     = 2'd0;
  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

  localparam logic [1:0] WB_EXU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_SNPC = 2'd2;

  localparam logic PC_SNPC = 1'b0;
  localparam logic PC_EXU  = 1'b1;

  function automatic logic is_onehot(input logic [IT_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/ysyx_25020047_wait_cnt.sv
// Memory-wait counter: clears on request, counts stalled cycles and flags the
// stall cycle after which the request is considered lost.
module ysyx_25020047_wait_cnt #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires on the stalled cycle that would bring the count up to TIMEOUT_CYC.
  assign o_expire = i_inc && (r_cnt == LP_LAST);

endmodule

// File: rtl/ysyx_25020047_seq_ctrl.sv
// NPC multi-cycle sequencer: FETCH -> EXEC -> (MEM) -> WB, owning the shared
// memory port, the write strobes, halt status and the retired-instruction count.
module ysyx_25020047_seq_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IT_W-1:0] inst_type,
  input  logic            exu_reg_wen,
  input  logic            exu_read,
  input  logic            exu_write,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_is_fetch,
  output logic            ir_we,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic [31:0]     instret
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [1:0]  r_halt_code;
  logic [1:0]  w_next_code;
  logic [31:0] r_instret;

  logic r_jump;
  logic r_branch;
  logic r_load;
  logic r_reg_wen;

  logic w_in_req;
  logic w_wait;
  logic w_expire;
  logic w_in_wb;

  assign w_in_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_wait   = w_in_req && !mem_ack;
  assign w_in_wb  = (r_state == ST_WB);

  // Anything other than a stalled request cycle is a state entry or exit.
  ysyx_25020047_wait_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_wait),
    .i_inc    (w_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next      = r_state;
    w_next_code = r_halt_code;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          w_next = ST_EXEC;
        end else if (w_expire) begin
          w_next      = ST_HALT;
          w_next_code = HC_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (!is_onehot(inst_type)) begin
          w_next      = ST_HALT;
          w_next_code = HC_ILLEGAL;
        end else if (inst_type[IT_EBREAK]) begin
          w_next      = ST_HALT;
          w_next_code = HC_EBREAK;
        end else if (exu_read || exu_write) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          w_next = ST_WB;
        end else if (w_expire) begin
          w_next      = ST_HALT;
          w_next_code = HC_TIMEOUT;
        end
      end
      ST_WB:   w_next = ST_FETCH;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_halt_code <= HC_RUN;
      r_instret   <= '0;
    end else begin
      r_state     <= w_next;
      r_halt_code <= w_next_code;
      if (w_in_wb) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // Instruction attributes captured on EXEC exit and held through MEM/WB.
  always_ff @(posedge clk) begin
    if (r_state == ST_EXEC) begin
      r_jump    <= inst_type[IT_JAL] || inst_type[IT_JALR];
      r_branch  <= inst_type[IT_BEQ] || inst_type[IT_BNE];
      r_load    <= exu_read || inst_type[IT_LW] || inst_type[IT_LBU];
      r_reg_wen <= exu_reg_wen;
    end
  end

  always_comb begin
    wb_sel = WB_EXU;
    if (w_in_wb) begin
      if (r_jump) begin
        wb_sel = WB_SNPC;
      end else if (r_load) begin
        wb_sel = WB_LOAD;
      end
    end
  end

  assign mem_req      = w_in_req;
  assign mem_is_fetch = (r_state == ST_FETCH);
  assign mem_we       = (r_state == ST_MEM) && exu_write;
  assign ir_we        = (r_state == ST_FETCH) && mem_ack;
  assign pc_we        = w_in_wb;
  assign pc_sel       = (w_in_wb && (r_jump || r_branch)) ? PC_EXU : PC_SNPC;
  assign rf_we        = w_in_wb && r_reg_wen;
  assign halt         = (r_state == ST_HALT);
  assign halt_code    = r_halt_code;
  assign instret      = r_instret;

endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// Directed bench for the NPC sequencer; inputs change 1ns after each rising
// edge and outputs are checked 1ns later, well clear of the next edge.
module tb_ysyx_25020047_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_type;
  logic        exu_reg_wen;
  logic        exu_read;
  logic        exu_write;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        ir_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        pc_sel;
  logic        halt;
  logic [1:0]  halt_code;
  logic [31:0] instret;

  int n_chk = 0;
  int n_err = 0;

  ysyx_25020047_seq_ctrl #(
    .TIMEOUT_CYC (4),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_type    (inst_type),
    .exu_reg_wen  (exu_reg_wen),
    .exu_read     (exu_read),
    .exu_write    (exu_write),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .halt         (halt),
    .halt_code    (halt_code),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  logic [11:0] w_obs;
  assign w_obs = {mem_req, mem_we, mem_is_fetch, ir_we, rf_we, wb_sel,
                  pc_we, pc_sel, halt, halt_code};

  function automatic logic [11:0] pk(input logic req, input logic we, input logic fetch,
                                     input logic ir, input logic rf, input logic [1:0] wbs,
                                     input logic pcwe, input logic pcs, input logic hlt,
                                     input logic [1:0] code);
    return {req, we, fetch, ir, rf, wbs, pcwe, pcs, hlt, code};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [11:0] exp);
    chk(tag, {20'd0, w_obs}, {20'd0, exp});
  endtask

  task automatic reset_pulse();
    rst = 1'b1; mem_ack = 1'b0;
    tick();
    chk_o("rst_outputs", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    chk("rst_instret", instret, 32'd0);
    rst = 1'b0;
  endtask

  // Runs one bad-type instruction from reset to HALT, then pokes it with acks.
  task automatic run_bad(input string tag, input logic [31:0] ty, input logic [1:0] code);
    reset_pulse();
    tick();
    inst_type = ty; exu_reg_wen = 1'b0; exu_read = 1'b0; exu_write = 1'b0; mem_ack = 1'b1;
    settle();
    chk_o({tag, "_fetch"}, pk(1,0,1,1,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o({tag, "_exec"}, pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    chk_o({tag, "_halt"}, pk(0,0,0,0,0,2'd0,0,0,1,code));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o({tag, "_halt_ack"}, pk(0,0,0,0,0,2'd0,0,0,1,code));
    tick();
    chk_o({tag, "_halt_hold"}, pk(0,0,0,0,0,2'd0,0,0,1,code));
    chk({tag, "_instret"}, instret, 32'd0);
  endtask

  initial begin
    rst = 1'b1; inst_type = '0; exu_reg_wen = 1'b0; exu_read = 1'b0;
    exu_write = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    chk_o("reset_state", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    chk("reset_instret", instret, 32'd0);

    // addi, zero-wait fetch
    rst = 1'b0;
    settle();
    chk_o("addi_idle", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    inst_type = 32'h1; exu_reg_wen = 1'b1; mem_ack = 1'b1;
    settle();
    chk_o("addi_fetch", pk(1,0,1,1,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("addi_exec", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    chk_o("addi_wb", pk(0,0,0,0,1,2'd0,1,0,0,2'd0));
    chk("addi_wb_instret", instret, 32'd0);
    tick();
    chk("addi_instret", instret, 32'd1);

    // lw, memory acks on the fourth MEM cycle
    inst_type = 32'h20; exu_read = 1'b1; exu_reg_wen = 1'b1; mem_ack = 1'b1;
    settle();
    chk_o("lw_fetch", pk(1,0,1,1,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("lw_exec", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ack = (i == 3);
      settle();
      chk_o($sformatf("lw_mem%0d", i), pk(1,0,0,0,0,2'd0,0,0,0,2'd0));
    end
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("lw_wb", pk(0,0,0,0,1,2'd1,1,0,0,2'd0));
    tick();
    chk("lw_instret", instret, 32'd2);

    // sw
    inst_type = 32'h80; exu_read = 1'b0; exu_write = 1'b1; exu_reg_wen = 1'b0; mem_ack = 1'b1;
    settle();
    chk_o("sw_fetch", pk(1,0,1,1,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("sw_exec", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b1;
    settle();
    chk_o("sw_mem", pk(1,1,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("sw_wb", pk(0,0,0,0,0,2'd0,1,0,0,2'd0));
    tick();
    chk("sw_instret", instret, 32'd3);

    // reset mid-FETCH, then jal followed by bne
    exu_write = 1'b0;
    reset_pulse();
    tick();
    inst_type = 32'h400; exu_reg_wen = 1'b1; mem_ack = 1'b1;
    settle();
    chk_o("jal_fetch", pk(1,0,1,1,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    tick();
    chk_o("jal_wb", pk(0,0,0,0,1,2'd2,1,1,0,2'd0));
    tick();
    inst_type = 32'h8000; exu_reg_wen = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk_o("bne_wb", pk(0,0,0,0,0,2'd0,1,1,0,2'd0));
    tick();
    chk("jal_bne_instret", instret, 32'd2);

    // illegal and ebreak
    run_bad("t0", 32'h0, 2'd2);
    run_bad("t3", 32'h3, 2'd2);
    run_bad("t4", 32'h4, 2'd1);
    reset_pulse();
    settle();
    chk_o("post_halt_idle", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));

    // fetch timeout with TIMEOUT_CYC = 4
    inst_type = 32'h1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_o($sformatf("to_fetch%0d", i), pk(1,0,1,0,0,2'd0,0,0,0,2'd0));
    end
    tick();
    chk_o("to_halt", pk(0,0,0,0,0,2'd0,0,0,1,2'd3));

    // reset while a load is waiting in MEM; a late ack must be ignored
    reset_pulse();
    tick();
    inst_type = 32'h20; exu_read = 1'b1; exu_reg_wen = 1'b1; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk_o("rm_mem", pk(1,0,0,0,0,2'd0,0,0,0,2'd0));
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1;
    settle();
    chk_o("rm_idle_ack", pk(0,0,0,0,0,2'd0,0,0,0,2'd0));
    tick();
    mem_ack = 1'b0;
    settle();
    chk_o("rm_fetch", pk(1,0,1,0,0,2'd0,0,0,0,2'd0));
    chk("rm_instret", instret, 32'd0);
    tick();
    chk_o("rm_fetch_hold", pk(1,0,1,0,0,2'd0,0,0,0,2'd0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
